nzp_cc_unit: RTL and testbench

- Parametrised condition-code unit, the successor to the single-set NZP register. Sits on the datapath bus.
- Latches N/Z/P from a WIDTH-bit bus value. Provides an LC-3 style branch-condition test.
- Adds a DEPTH-entry save/restore stack so interrupt/trap entry can push the flags and RTI can pop them back.
- Reports stack full/empty and sticky overflow/underflow errors.

---
 rtl/nzp_cc_unit.sv | 103 ++++++++++
 tb/tb_nzp_cc_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nzp_cc_unit.sv
// LC-3 style N/Z/P condition-code register with branch test and a bounded
// save/restore stack for interrupt/trap entry and RTI.
module nzp_cc_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flagWE,
  input  logic [WIDTH-1:0] Buss,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [2:0]       br_nzp,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             br_taken,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             ovf_err,
  output logic             udf_err,
  output logic [PTR_W-1:0] depth_cnt
);

  // Storage is rounded up to a power of two so the index width matches exactly.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 2 ** IDX_W;

  logic [2:0]       r_flags;
  logic [PTR_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;
  logic [2:0]       r_stack [SLOTS];

  logic             w_full;
  logic             w_empty;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] v);
    logic sgn;
    logic nz;
    sgn = v[WIDTH-1];
    nz  = |v;
    return {sgn, ~nz, nz & ~sgn};
  endfunction

  assign w_full      = (r_cnt == PTR_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_do_push   = w_push_only & ~w_full;
  assign w_do_pop    = w_pop_only & ~w_empty;
  assign w_ovf_evt   = w_push_only & w_full;
  assign w_udf_evt   = w_pop_only & w_empty;
  assign w_wr_idx    = IDX_W'(r_cnt);
  assign w_rd_idx    = IDX_W'(r_cnt - PTR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 3'b010;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      // A restoring pop overrides any same-cycle flag load.
      if (w_do_pop)
        r_flags <= r_stack[w_rd_idx];
      else if (flagWE)
        r_flags <= f_nzp(Buss);

      if (w_do_push)
        r_cnt <= r_cnt + PTR_W'(1);
      else if (w_do_pop)
        r_cnt <= r_cnt - PTR_W'(1);

      r_ovf <= w_ovf_evt | (r_ovf & ~err_clr);
      r_udf <= w_udf_evt | (r_udf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !reset)
      r_stack[w_wr_idx] <= r_flags;
  end

  assign {N, Z, P}   = r_flags;
  assign br_taken    = |(br_nzp & r_flags);
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf_err     = r_ovf;
  assign udf_err     = r_udf;
  assign depth_cnt   = r_cnt;

endmodule

// File: tb/tb_nzp_cc_unit.sv
// Scoreboard bench for nzp_cc_unit: a 16-bit/4-deep and an 8-bit/1-deep instance.
module tb_nzp_cc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_fwe = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_clr = 1'b0;
  logic [15:0] a_bus = '0;
  logic [2:0]  a_br = '0;
  logic        a_n, a_z, a_p, a_brt, a_full, a_empty, a_ovf, a_udf;
  logic [2:0]  a_cnt;

  logic        b_rst = 1'b1, b_fwe = 1'b0, b_push = 1'b0, b_pop = 1'b0, b_clr = 1'b0;
  logic [7:0]  b_bus = '0;
  logic [2:0]  b_br = '0;
  logic        b_n, b_z, b_p, b_brt, b_full, b_empty, b_ovf, b_udf;
  logic [0:0]  b_cnt;

  nzp_cc_unit #(.WIDTH(16), .DEPTH(4)) u_a (
    .clk(clk), .reset(a_rst), .flagWE(a_fwe), .Buss(a_bus), .push(a_push), .pop(a_pop),
    .err_clr(a_clr), .br_nzp(a_br), .N(a_n), .Z(a_z), .P(a_p), .br_taken(a_brt),
    .stack_full(a_full), .stack_empty(a_empty), .ovf_err(a_ovf), .udf_err(a_udf),
    .depth_cnt(a_cnt));

  nzp_cc_unit #(.WIDTH(8), .DEPTH(1)) u_b (
    .clk(clk), .reset(b_rst), .flagWE(b_fwe), .Buss(b_bus), .push(b_push), .pop(b_pop),
    .err_clr(b_clr), .br_nzp(b_br), .N(b_n), .Z(b_z), .P(b_p), .br_taken(b_brt),
    .stack_full(b_full), .stack_empty(b_empty), .ovf_err(b_ovf), .udf_err(b_udf),
    .depth_cnt(b_cnt));

  typedef struct {
    int          cyc;
    bit          which;
    string       name;
    logic [10:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  // Packs {N,Z,P, br_taken, full, empty, ovf, udf, depth_cnt[2:0]}
  function automatic logic [10:0] ex(input logic [2:0] nzp, input logic br, input logic full,
                                     input logic empty, input logic ovf, input logic udf,
                                     input logic [2:0] cnt);
    return {nzp, br, full, empty, ovf, udf, cnt};
  endfunction

  task automatic drv_a(input logic rs, input logic fwe, input logic [15:0] bus,
                       input logic pu, input logic po, input logic ec, input logic [2:0] brm,
                       input string nm, input logic [10:0] ev);
    exp_t e;
    @(negedge clk);
    a_rst = rs; a_fwe = fwe; a_bus = bus; a_push = pu; a_pop = po; a_clr = ec; a_br = brm;
    e.cyc = cyc_cnt + 1; e.which = 1'b0; e.name = nm; e.vec = ev;
    q.push_back(e);
  endtask

  task automatic drv_b(input logic rs, input logic fwe, input logic [7:0] bus,
                       input logic pu, input logic po, input logic ec, input logic [2:0] brm,
                       input string nm, input logic [10:0] ev);
    exp_t e;
    @(negedge clk);
    b_rst = rs; b_fwe = fwe; b_bus = bus; b_push = pu; b_pop = po; b_clr = ec; b_br = brm;
    e.cyc = cyc_cnt + 1; e.which = 1'b1; e.name = nm; e.vec = ev;
    q.push_back(e);
  endtask

  // Monitor: after each rising edge, retire every expectation due by now.
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        if (e.which == 1'b0)
          act = {a_n, a_z, a_p, a_brt, a_full, a_empty, a_ovf, a_udf, a_cnt};
        else
          act = {b_n, b_z, b_p, b_brt, b_full, b_empty, b_ovf, b_udf, 2'b00, b_cnt};
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL %s: got nzp/br/full/empty/ovf/udf/cnt=%b want %b", e.name, act, e.vec);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    // Instance A: WIDTH=16, DEPTH=4
    drv_a(1, 0, 16'h0000, 0, 0, 0, 3'b010, "a_reset",      ex(3'b010, 1, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h8000, 0, 0, 0, 3'b010, "a_ld_8000",    ex(3'b100, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h0000, 0, 0, 0, 3'b010, "a_ld_0000",    ex(3'b010, 1, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h0001, 0, 0, 0, 3'b010, "a_ld_0001",    ex(3'b001, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h7FFF, 0, 0, 0, 3'b010, "a_ld_7fff",    ex(3'b001, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'hFFFF, 1, 0, 0, 3'b000, "a_push_ld",    ex(3'b100, 0, 0, 0, 0, 0, 3'd1));
    drv_a(0, 0, 16'h0000, 0, 1, 0, 3'b001, "a_pop_rest",   ex(3'b001, 1, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h8000, 0, 0, 0, 3'b100, "a_ld_n",       ex(3'b100, 1, 0, 1, 0, 0, 3'd0));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_push1",      ex(3'b100, 0, 0, 0, 0, 0, 3'd1));
    drv_a(0, 1, 16'h0000, 0, 0, 0, 3'b000, "a_ld_z",       ex(3'b010, 0, 0, 0, 0, 0, 3'd1));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_push2",      ex(3'b010, 0, 0, 0, 0, 0, 3'd2));
    drv_a(0, 1, 16'h0005, 0, 0, 0, 3'b000, "a_ld_p",       ex(3'b001, 0, 0, 0, 0, 0, 3'd2));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_push3",      ex(3'b001, 0, 0, 0, 0, 0, 3'd3));
    drv_a(0, 1, 16'h8000, 0, 0, 0, 3'b000, "a_ld_n2",      ex(3'b100, 0, 0, 0, 0, 0, 3'd3));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_push4_full", ex(3'b100, 0, 1, 0, 0, 0, 3'd4));
    drv_a(0, 1, 16'h0000, 0, 0, 0, 3'b000, "a_ld_z2",      ex(3'b010, 0, 1, 0, 0, 0, 3'd4));
    drv_a(0, 1, 16'hFFFF, 1, 0, 0, 3'b000, "a_push5_ovf",  ex(3'b100, 0, 1, 0, 1, 0, 3'd4));
    drv_a(0, 0, 16'h0000, 0, 1, 0, 3'b000, "a_pop4",       ex(3'b100, 0, 0, 0, 1, 0, 3'd3));
    drv_a(0, 1, 16'h0001, 0, 1, 0, 3'b000, "a_pop3_prio",  ex(3'b001, 0, 0, 0, 1, 0, 3'd2));
    drv_a(0, 0, 16'h0000, 0, 1, 0, 3'b000, "a_pop2",       ex(3'b010, 0, 0, 0, 1, 0, 3'd1));
    drv_a(0, 0, 16'h0000, 0, 1, 0, 3'b000, "a_pop1",       ex(3'b100, 0, 0, 1, 1, 0, 3'd0));
    drv_a(0, 0, 16'h0000, 0, 0, 1, 3'b000, "a_clr_ovf",    ex(3'b100, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 1, 16'h0000, 0, 1, 0, 3'b000, "a_udf_ld",     ex(3'b010, 0, 0, 1, 0, 1, 3'd0));
    drv_a(0, 0, 16'h0000, 0, 0, 1, 3'b000, "a_clr_udf",    ex(3'b010, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 0, 16'h0000, 0, 1, 1, 3'b000, "a_clr_vs_udf", ex(3'b010, 0, 0, 1, 0, 1, 3'd0));
    drv_a(0, 0, 16'h0000, 0, 0, 1, 3'b000, "a_clr_udf2",   ex(3'b010, 0, 0, 1, 0, 0, 3'd0));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_pp_push1",   ex(3'b010, 0, 0, 0, 0, 0, 3'd1));
    drv_a(0, 1, 16'h8000, 0, 0, 0, 3'b000, "a_pp_ld",      ex(3'b100, 0, 0, 0, 0, 0, 3'd1));
    drv_a(0, 0, 16'h0000, 1, 0, 0, 3'b000, "a_pp_push2",   ex(3'b100, 0, 0, 0, 0, 0, 3'd2));
    drv_a(0, 1, 16'h0001, 1, 1, 0, 3'b000, "a_push_pop",   ex(3'b001, 0, 0, 0, 0, 0, 3'd2));
    drv_a(1, 0, 16'h0000, 1, 0, 0, 3'b000, "a_rst_mid",    ex(3'b010, 0, 0, 1, 0, 0, 3'd0));
    // Instance B: WIDTH=8, DEPTH=1
    drv_b(1, 0, 8'h00, 0, 0, 0, 3'b010, "b_reset",         ex(3'b010, 1, 0, 1, 0, 0, 3'd0));
    drv_b(0, 1, 8'h80, 0, 0, 0, 3'b010, "b_ld_80",         ex(3'b100, 0, 0, 1, 0, 0, 3'd0));
    drv_b(0, 1, 8'h7F, 0, 0, 0, 3'b001, "b_ld_7f",         ex(3'b001, 1, 0, 1, 0, 0, 3'd0));
    drv_b(0, 0, 8'h00, 1, 0, 0, 3'b000, "b_push_full",     ex(3'b001, 0, 1, 0, 0, 0, 3'd1));
    drv_b(0, 0, 8'h00, 1, 0, 0, 3'b000, "b_push_ovf",      ex(3'b001, 0, 1, 0, 1, 0, 3'd1));
    drv_b(0, 1, 8'h80, 0, 1, 0, 3'b000, "b_pop",           ex(3'b001, 0, 0, 1, 1, 0, 3'd0));
    @(negedge clk);
    a_push = 1'b0; a_pop = 1'b0; a_fwe = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_fwe = 1'b0;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
